// File: rtl/csru_pkg.sv
// Shared constants, op/state encodings and address-map helpers for the CSR unit.
// CSRU_MCYCLE_EN adds mcycle/mcycleh to the implemented address map.
package csru_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  localparam logic [CPU_WIDTH-1:0] IRQ_ECALL = 32'd11;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } csru_state_e;

  // Trap vector and exception PC are word aligned on every write path.
  function automatic logic [CPU_WIDTH-1:0] csr_field_mask(
    input logic [11:0]          addr,
    input logic [CPU_WIDTH-1:0] val
  );
    logic [CPU_WIDTH-1:0] res;
    res = val;
    if (addr == CSR_MTVEC || addr == CSR_MEPC) begin
      res[1:0] = '0;
    end
    return res;
  endfunction

  function automatic logic csr_implemented(input logic [11:0] addr);
    logic hit;
    hit = (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
          (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
`ifdef CSRU_MCYCLE_EN
    hit = hit || (addr == CSR_MCYCLE) || (addr == CSR_MCYCLEH);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational Zicsr new-value computation (RW/RS/RC) with per-register field masks.
module csr_alu
  import csru_pkg::*;
(
  input  logic [1:0]           i_op,
  input  logic [11:0]          i_addr,
  input  logic [CPU_WIDTH-1:0] i_old,
  input  logic [CPU_WIDTH-1:0] i_src,
  output logic [CPU_WIDTH-1:0] o_wdata
);

  logic [CPU_WIDTH-1:0] raw;

  always_comb begin
    raw = i_old;
    case (csr_op_e'(i_op))
      CSR_OP_RW: raw = i_src;
      CSR_OP_RS: raw = i_old | i_src;
      CSR_OP_RC: raw = i_old & ~i_src;
      default:   raw = i_old;
    endcase
    o_wdata = csr_field_mask(i_addr, raw);
  end

endmodule

// File: rtl/csru.sv
// Machine-mode CSR file: Zicsr execute with IDU-latch / LSU-commit handshake plus trap writes.
// Define CSRU_MCYCLE_EN to add the 64-bit mcycle counter at 0xB00/0xB80.
module csru
  import csru_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_idu_valid,
  input  logic                 i_lsu_valid,
  input  logic [1:0]           i_csr_op,
  input  logic [11:0]          i_csr_addr,
  input  logic [CPU_WIDTH-1:0] i_csr_src,
  output logic [CPU_WIDTH-1:0] o_csr_rdata,
  output logic                 o_csr_busy,
  output logic                 o_csr_illegal,
  input  logic                 i_mepc_wen,
  input  logic [CPU_WIDTH-1:0] i_mepc_wdata,
  input  logic                 i_mcause_wen,
  input  logic [CPU_WIDTH-1:0] i_mcause_wdata,
  input  logic                 i_mstatus_wen,
  input  logic [CPU_WIDTH-1:0] i_mstatus_wdata,
  output logic [CPU_WIDTH-1:0] o_mstatus,
  output logic [CPU_WIDTH-1:0] o_mtvec,
  output logic [CPU_WIDTH-1:0] o_mepc
);

  csru_state_e          state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [11:0]          addr_q, addr_d;
  logic [CPU_WIDTH-1:0] src_q, src_d;
  logic [CPU_WIDTH-1:0] rdata_q, rdata_d;
  logic [CPU_WIDTH-1:0] mstatus_q, mstatus_d;
  logic [CPU_WIDTH-1:0] mtvec_q, mtvec_d;
  logic [CPU_WIDTH-1:0] mepc_q, mepc_d;
  logic [CPU_WIDTH-1:0] mcause_q, mcause_d;
`ifdef CSRU_MCYCLE_EN
  logic [63:0]          mcycle_q, mcycle_d;
  logic [63:0]          mcycle_inc;
`endif

  logic                 commit;
  logic                 launch;
  logic [CPU_WIDTH-1:0] alu_wdata;
  logic [CPU_WIDTH-1:0] rd_val;

  csr_alu u_alu (
    .i_op    (op_q),
    .i_addr  (addr_q),
    .i_old   (rdata_q),
    .i_src   (src_q),
    .o_wdata (alu_wdata)
  );

  always_comb begin
    commit = (state_q == ST_PEND) && i_lsu_valid;
    launch = i_idu_valid && (csr_op_e'(i_csr_op) != CSR_OP_NONE) &&
             ((state_q == ST_IDLE) || commit);

    state_d = state_q;
    if (launch) begin
      state_d = ST_PEND;
    end else if (commit) begin
      state_d = ST_IDLE;
    end

    op_d   = launch ? i_csr_op   : op_q;
    addr_d = launch ? i_csr_addr : addr_q;
    src_d  = launch ? i_csr_src  : src_q;

    // Trap-unit writes are applied after the instruction commit so they win on collision.
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (commit) begin
      case (addr_q)
        CSR_MSTATUS: mstatus_d = alu_wdata;
        CSR_MTVEC:   mtvec_d   = alu_wdata;
        CSR_MEPC:    mepc_d    = alu_wdata;
        CSR_MCAUSE:  mcause_d  = alu_wdata;
        default: ;
      endcase
    end
    if (i_mstatus_wen) mstatus_d = i_mstatus_wdata;
    if (i_mepc_wen)    mepc_d    = csr_field_mask(CSR_MEPC, i_mepc_wdata);
    if (i_mcause_wen)  mcause_d  = i_mcause_wdata;

`ifdef CSRU_MCYCLE_EN
    mcycle_inc = mcycle_q + 64'd1;
    mcycle_d   = mcycle_inc;
    if (commit && addr_q == CSR_MCYCLE)  mcycle_d[31:0]  = alu_wdata;
    if (commit && addr_q == CSR_MCYCLEH) mcycle_d[63:32] = alu_wdata;
`endif

    // Old value is sampled from next-state so a back-to-back op sees the write committing now.
    case (i_csr_addr)
      CSR_MSTATUS: rd_val = mstatus_d;
      CSR_MTVEC:   rd_val = mtvec_d;
      CSR_MEPC:    rd_val = mepc_d;
      CSR_MCAUSE:  rd_val = mcause_d;
`ifdef CSRU_MCYCLE_EN
      CSR_MCYCLE:  rd_val = mcycle_d[31:0];
      CSR_MCYCLEH: rd_val = mcycle_d[63:32];
`endif
      default:     rd_val = '0;
    endcase
    rdata_d = launch ? rd_val : rdata_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      src_q     <= '0;
      rdata_q   <= '0;
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= MTVEC_RST;
      mepc_q    <= '0;
      mcause_q  <= '0;
`ifdef CSRU_MCYCLE_EN
      mcycle_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      src_q     <= src_d;
      rdata_q   <= rdata_d;
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
`ifdef CSRU_MCYCLE_EN
      mcycle_q  <= mcycle_d;
`endif
    end
  end

  assign o_csr_rdata   = rdata_q;
  assign o_csr_busy    = (state_q == ST_PEND);
  assign o_csr_illegal = (state_q == ST_PEND) && !csr_implemented(addr_q);
  assign o_mstatus     = mstatus_q;
  assign o_mtvec       = mtvec_q;
  assign o_mepc        = mepc_q;

endmodule

// File: tb/tb_csru.sv
// Self-checking bench for csru: directed scenarios plus randomized traffic against a register-array model.
module tb_csru;
  import csru_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idu_valid, lsu_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_src;
  logic [31:0] csr_rdata;
  logic        csr_busy, csr_illegal;
  logic        mepc_wen, mcause_wen, mstatus_wen;
  logic [31:0] mepc_wdata, mcause_wdata, mstatus_wdata;
  logic [31:0] mstatus, mtvec, mepc;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference state: architectural registers indexed 0..3 (mstatus, mtvec, mepc, mcause).
  logic [31:0] mreg [4];
  bit          m_pend;
  logic [1:0]  m_op;
  logic [11:0] m_addr;
  logic [31:0] m_src;
  logic [31:0] m_old;

  csru #(
    .MTVEC_RST   (32'h0000_0000),
    .MSTATUS_RST (32'h0000_1800)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_idu_valid     (idu_valid),
    .i_lsu_valid     (lsu_valid),
    .i_csr_op        (csr_op),
    .i_csr_addr      (csr_addr),
    .i_csr_src       (csr_src),
    .o_csr_rdata     (csr_rdata),
    .o_csr_busy      (csr_busy),
    .o_csr_illegal   (csr_illegal),
    .i_mepc_wen      (mepc_wen),
    .i_mepc_wdata    (mepc_wdata),
    .i_mcause_wen    (mcause_wen),
    .i_mcause_wdata  (mcause_wdata),
    .i_mstatus_wen   (mstatus_wen),
    .i_mstatus_wdata (mstatus_wdata),
    .o_mstatus       (mstatus),
    .o_mtvec         (mtvec),
    .o_mepc          (mepc)
  );

  always #5 clk = ~clk;

  function automatic int ridx(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mreg[0] = 32'h0000_1800;
    mreg[1] = 32'h0;
    mreg[2] = 32'h0;
    mreg[3] = 32'h0;
    m_pend  = 1'b0;
    m_old   = 32'h0;
    m_op    = 2'b00;
    m_addr  = 12'h0;
    m_src   = 32'h0;
  endtask

  task automatic model_edge();
    bit          commit, launch;
    int          k;
    logic [31:0] nv;
    commit = m_pend && lsu_valid;
    launch = idu_valid && (csr_op != 2'b00) && (!m_pend || commit);
    if (commit) begin
      k = ridx(m_addr);
      if (k >= 0) begin
        if (m_op == 2'b01)      nv = m_src;
        else if (m_op == 2'b10) nv = m_old | m_src;
        else                    nv = m_old & ~m_src;
        if (k == 1 || k == 2) nv = nv & 32'hFFFF_FFFC;
        mreg[k] = nv;
      end
    end
    if (mstatus_wen) mreg[0] = mstatus_wdata;
    if (mepc_wen)    mreg[2] = mepc_wdata & 32'hFFFF_FFFC;
    if (mcause_wen)  mreg[3] = mcause_wdata;
    if (launch) begin
      k = ridx(csr_addr);
      m_old  = (k >= 0) ? mreg[k] : 32'h0;
      m_op   = csr_op;
      m_addr = csr_addr;
      m_src  = csr_src;
      m_pend = 1'b1;
    end else if (commit) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ":busy"},    {31'b0, csr_busy},    {31'b0, m_pend});
    chk({where, ":illegal"}, {31'b0, csr_illegal}, {31'b0, m_pend && ridx(m_addr) < 0});
    chk({where, ":rdata"},   csr_rdata, m_old);
    chk({where, ":mstatus"}, mstatus,   mreg[0]);
    chk({where, ":mtvec"},   mtvec,     mreg[1]);
    chk({where, ":mepc"},    mepc,      mreg[2]);
  endtask

  task automatic drive(input logic idu, input logic lsu, input logic [1:0] op,
                       input logic [11:0] addr, input logic [31:0] src);
    idu_valid   = idu;
    lsu_valid   = lsu;
    csr_op      = op;
    csr_addr    = addr;
    csr_src     = src;
    mepc_wen    = 1'b0;
    mcause_wen  = 1'b0;
    mstatus_wen = 1'b0;
  endtask

  task automatic cycle(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_all(where);
  endtask

  initial begin
    logic [11:0] addrs [5];
    addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0};
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 12'h0, 32'h0);
    mepc_wdata = '0; mcause_wdata = '0; mstatus_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_mstatus_const", mstatus, 32'h0000_1800);
    rst_n = 1'b1;

    // mcause reads 0 out of reset
    drive(1'b1, 1'b0, CSR_OP_RS, CSR_MCAUSE, 32'h0);
    cycle("rd_mcause");
    chk("mcause_rst_rdata", csr_rdata, 32'h0);
    drive(1'b0, 1'b1, 2'b00, 12'h0, 32'h0);
    cycle("rd_mcause_commit");

    // CSRRW mtvec with commit two cycles after decode
    drive(1'b1, 1'b0, CSR_OP_RW, CSR_MTVEC, 32'h8000_0103);
    cycle("mtvec_dec");
    chk("mtvec_old", csr_rdata, 32'h0);
    drive(1'b0, 1'b0, 2'b00, 12'h0, 32'h0);
    cycle("mtvec_wait");
    drive(1'b1, 1'b1, CSR_OP_RW, CSR_MEPC, 32'h0);
    idu_valid = 1'b0;
    cycle("mtvec_commit");
    chk("mtvec_masked", mtvec, 32'h8000_0100);

    // back-to-back RS then RC on mstatus
    drive(1'b1, 1'b0, CSR_OP_RS, CSR_MSTATUS, 32'h8);
    cycle("ms_rs_dec");
    chk("ms_rs_old", csr_rdata, 32'h1800);
    drive(1'b1, 1'b1, CSR_OP_RC, CSR_MSTATUS, 32'h1000);
    cycle("ms_b2b");
    chk("ms_rc_old", csr_rdata, 32'h1808);
    drive(1'b0, 1'b1, 2'b00, 12'h0, 32'h0);
    cycle("ms_rc_commit");
    chk("ms_final", mstatus, 32'h0808);

    // trap write to mepc collides with instruction commit to mepc
    drive(1'b1, 1'b0, CSR_OP_RW, CSR_MEPC, 32'h1234);
    cycle("mepc_dec");
    drive(1'b0, 1'b1, 2'b00, 12'h0, 32'h0);
    mepc_wen = 1'b1; mepc_wdata = 32'h8000_0040;
    mcause_wen = 1'b1; mcause_wdata = IRQ_ECALL;
    cycle("mepc_collide");
    chk("mepc_trap_wins", mepc, 32'h8000_0040);
    drive(1'b1, 1'b0, CSR_OP_RS, CSR_MCAUSE, 32'h0);
    cycle("mcause_rd");
    chk("mcause_ecall", csr_rdata, IRQ_ECALL);
    drive(1'b0, 1'b1, 2'b00, 12'h0, 32'h0);
    cycle("mcause_commit");

    // unimplemented address
    drive(1'b1, 1'b0, CSR_OP_RW, 12'h7C0, 32'hFFFF_FFFF);
    cycle("ill_dec");
    chk("ill_flag", {31'b0, csr_illegal}, 32'h1);
    chk("ill_rdata", csr_rdata, 32'h0);
    drive(1'b1, 1'b0, CSR_OP_RW, CSR_MTVEC, 32'h0);
    cycle("ill_stall");
    drive(1'b0, 1'b1, 2'b00, 12'h0, 32'h0);
    cycle("ill_commit");

    // reset while pending
    drive(1'b1, 1'b0, CSR_OP_RW, CSR_MTVEC, 32'hABCD_0000);
    cycle("rst_dec");
    drive(1'b0, 1'b0, 2'b00, 12'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy_drop", {31'b0, csr_busy}, 32'h0);
    check_all("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 2'b00, 12'h0, 32'h0);
    cycle("rst_post");
    chk("rst_no_write", mtvec, 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
            2'($urandom_range(0, 3)), addrs[$urandom_range(0, 4)], $urandom);
      mstatus_wen   = ($urandom_range(0, 7) == 0);
      mstatus_wdata = $urandom;
      mepc_wen      = ($urandom_range(0, 7) == 0);
      mepc_wdata    = $urandom;
      mcause_wen    = ($urandom_range(0, 7) == 0);
      mcause_wdata  = $urandom;
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
